// File: rtl/accum_pkg.sv
// Shared constants and helpers for the multi-channel accumulator.
// Imported by the interface, the lane and the top.
package accum_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH;
  localparam int DEF_SATURATE   = 0;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CLR,
    OP_LOAD,
    OP_ADD
  } lane_op_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_accumulator_if.sv
// Command/result bundle between a driver and the accumulator.
// clk and reset stay as plain ports on the modules.
interface multi_accumulator_if
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH
);
  localparam int CW = ch_width(NUM_CH);

  logic                  valid;
  logic [CW-1:0]         ch;
  logic                  clear;
  logic                  load;
  logic [DATA_WIDTH-1:0] value;
  logic                  display;
  logic [CW-1:0]         disp_ch;
  logic [ACC_WIDTH-1:0]  sum;
  logic                  sum_valid;
  logic [NUM_CH-1:0]     ovf;

  modport master (
    output valid, ch, clear, load, value,
    output display, disp_ch,
    input  sum, sum_valid, ovf
  );

  modport slave (
    input  valid, ch, clear, load, value,
    input  display, disp_ch,
    output sum, sum_valid, ovf
  );
endinterface

// File: rtl/acc_lane.sv
// One accumulator channel: clear/load/add with sticky overflow
// and optional clamp-to-all-ones on carry out.
module acc_lane
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SATURATE   = DEF_SATURATE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  lane_op_e              op,
  input  logic [DATA_WIDTH-1:0] value,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  ovf
);

  logic [ACC_WIDTH:0]   sum_w;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 ovf_d;

  // next accumulator and overflow state for the decoded op
  always_comb begin
    sum_w = {1'b0, acc}
          + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, value};
    acc_d = acc;
    ovf_d = ovf;
    unique case (op)
      OP_CLR: begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
      OP_LOAD: begin
        acc_d = {{(ACC_WIDTH - DATA_WIDTH){1'b0}}, value};
      end
      OP_ADD: begin
        acc_d = sum_w[ACC_WIDTH-1:0];
        if (sum_w[ACC_WIDTH]) begin
          ovf_d = 1'b1;
          if (SATURATE != 0) acc_d = '1;
        end
      end
      default: ;
    endcase
  end

  // lane state register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_d;
      ovf <= ovf_d;
    end
  end

endmodule

// File: rtl/multi_accumulator.sv
// NUM_CH independent accumulators with a registered display port.
// Lanes hold the arithmetic; the top decodes ops and owns sum.
module multi_accumulator
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH,
  parameter int SATURATE   = DEF_SATURATE
) (
  input logic               clk,
  input logic               reset,
  multi_accumulator_if.slave bus
);

  localparam int CW = ch_width(NUM_CH);

  logic [ACC_WIDTH-1:0] acc [NUM_CH];
  logic [NUM_CH-1:0]    ovf_w;
  logic                 ch_ok;
  logic                 disp_ok;
  logic [ACC_WIDTH-1:0] sum_q;
  logic                 sum_valid_q;

  // out-of-range channel numbers are silently dropped
  always_comb begin
    ch_ok   = int'(bus.ch) < NUM_CH;
    disp_ok = int'(bus.disp_ch) < NUM_CH;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    lane_op_e op;
    logic     hit;

    // select the op for this lane; clear beats load beats add
    always_comb begin
      op  = OP_NONE;
      hit = bus.valid && ch_ok
         && (int'(bus.ch) == i);
      if (hit) begin
        unique case (1'b1)
          bus.clear:               op = OP_CLR;
          !bus.clear && bus.load:  op = OP_LOAD;
          !bus.clear && !bus.load: op = OP_ADD;
          default:                 op = OP_NONE;
        endcase
      end
    end

    acc_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SATURATE  (SATURATE)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .op   (op),
      .value(bus.value),
      .acc  (acc[i]),
      .ovf  (ovf_w[i])
    );
  end

  // capture the pre-edge accumulator; pulse valid for one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= bus.display && disp_ok;
      if (bus.display && disp_ok) begin
        sum_q <= acc[bus.disp_ch];
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.ovf       = ovf_w;

endmodule

// File: tb/tb_multi_accumulator.sv
// Directed bench for multi_accumulator with an arithmetic model.
// Three builds: 16-bit wrap, 10-bit wrap, 10-bit saturate.
module tb_multi_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [1:0] ch;
  logic       clear;
  logic       load;
  logic [7:0] value;
  logic       display;
  logic [1:0] disp_ch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_accumulator_if #(.DATA_WIDTH(8), .NUM_CH(4), .ACC_WIDTH(16)) bus0 ();
  multi_accumulator_if #(.DATA_WIDTH(8), .NUM_CH(4), .ACC_WIDTH(10)) bus1 ();
  multi_accumulator_if #(.DATA_WIDTH(8), .NUM_CH(4), .ACC_WIDTH(10)) bus2 ();

  assign bus0.valid = valid;   assign bus1.valid = valid;   assign bus2.valid = valid;
  assign bus0.ch = ch;         assign bus1.ch = ch;         assign bus2.ch = ch;
  assign bus0.clear = clear;   assign bus1.clear = clear;   assign bus2.clear = clear;
  assign bus0.load = load;     assign bus1.load = load;     assign bus2.load = load;
  assign bus0.value = value;   assign bus1.value = value;   assign bus2.value = value;
  assign bus0.display = display; assign bus1.display = display; assign bus2.display = display;
  assign bus0.disp_ch = disp_ch; assign bus1.disp_ch = disp_ch; assign bus2.disp_ch = disp_ch;

  multi_accumulator #(.DATA_WIDTH(8), .NUM_CH(4), .ACC_WIDTH(16), .SATURATE(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  multi_accumulator #(.DATA_WIDTH(8), .NUM_CH(4), .ACC_WIDTH(10), .SATURATE(0))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  multi_accumulator #(.DATA_WIDTH(8), .NUM_CH(4), .ACC_WIDTH(10), .SATURATE(1))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // model: plain integers per build
  longint   m_acc [3][4];
  longint   m_sum [3];
  bit       m_sv  [3];
  bit [3:0] m_ovf [3];
  bit       armed = 1'b0;

  function automatic longint acc_max(input int k);
    return (k == 0) ? 64'hFFFF : 64'h3FF;
  endfunction

  always @(posedge clk) begin
    longint t;
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        for (int c = 0; c < 4; c++) m_acc[k][c] = 0;
        m_sum[k] = 0;
        m_sv[k]  = 1'b0;
        m_ovf[k] = 4'b0;
      end else begin
        m_sv[k] = display;
        if (display) m_sum[k] = m_acc[k][disp_ch];
        if (valid) begin
          if (clear) begin
            m_acc[k][ch] = 0;
            m_ovf[k][ch] = 1'b0;
          end else if (load) begin
            m_acc[k][ch] = longint'(value);
          end else begin
            t = m_acc[k][ch] + longint'(value);
            if (t > acc_max(k)) begin
              m_ovf[k][ch] = 1'b1;
              t = (k == 2) ? acc_max(k) : t - (acc_max(k) + 1);
            end
            m_acc[k][ch] = t;
          end
        end
      end
    end
    if (!reset) armed = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("m0.sum", 64'(bus0.sum), m_sum[0]);
      chk("m0.sv",  64'(bus0.sum_valid), 64'(m_sv[0]));
      chk("m0.ovf", 64'(bus0.ovf), 64'(m_ovf[0]));
      chk("m1.sum", 64'(bus1.sum), m_sum[1]);
      chk("m1.sv",  64'(bus1.sum_valid), 64'(m_sv[1]));
      chk("m1.ovf", 64'(bus1.ovf), 64'(m_ovf[1]));
      chk("m2.sum", 64'(bus2.sum), m_sum[2]);
      chk("m2.sv",  64'(bus2.sum_valid), 64'(m_sv[2]));
      chk("m2.ovf", 64'(bus2.ovf), 64'(m_ovf[2]));
    end
  end

  task automatic step(input logic v, input logic [1:0] c,
                      input logic clr, input logic ld,
                      input logic [7:0] val, input logic d,
                      input logic [1:0] dc);
    valid = v; ch = c; clear = clr; load = ld;
    value = val; display = d; disp_ch = dc;
    @(posedge clk);
    #2;
  endtask

  task automatic add(input logic [1:0] c, input logic [7:0] val);
    step(1, c, 0, 0, val, 0, 0);
  endtask

  task automatic show(input logic [1:0] dc);
    step(0, 0, 0, 0, 0, 1, dc);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    idle();
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      show(2'(i));
      chk("rst.sum", 64'(bus0.sum), 64'h0);
      chk("rst.sv", 64'(bus0.sum_valid), 64'h1);
    end
    idle();
    chk("rst.sv_drop", 64'(bus0.sum_valid), 64'h0);
    chk("rst.ovf", 64'(bus0.ovf), 64'h0);

    add(0, 8'd1);
    add(0, 8'd2);
    add(0, 8'd4);
    show(0);
    chk("add7", 64'(bus0.sum), 64'h7);
    add(0, 8'd4);
    chk("hold7", 64'(bus0.sum), 64'h7);
    chk("hold.sv", 64'(bus0.sum_valid), 64'h0);
    show(0);
    chk("addB", 64'(bus0.sum), 64'hB);

    step(1, 1, 0, 1, 8'd5, 0, 0);
    for (int i = 0; i < 4; i++) add(2, 8'hFF);
    show(1);
    chk("load5", 64'(bus0.sum), 64'h5);
    show(2);
    chk("ch2", 64'(bus0.sum), 64'h3FC);
    show(3);
    chk("ch3zero", 64'(bus0.sum), 64'h0);

    step(0, 1, 1, 1, 8'h33, 0, 0);
    show(1);
    chk("novalid", 64'(bus0.sum), 64'h5);

    for (int i = 0; i < 5; i++) add(3, 8'hFF);
    show(3);
    chk("w16.sum", 64'(bus0.sum), 64'h4FB);
    chk("w10.sum", 64'(bus1.sum), 64'h0FB);
    chk("s10.sum", 64'(bus2.sum), 64'h3FF);
    chk("w16.ovf", 64'(bus0.ovf), 64'h0);
    chk("w10.ovf", 64'(bus1.ovf), 64'h8);
    chk("s10.ovf", 64'(bus2.ovf), 64'h8);
    step(1, 3, 0, 1, 8'h01, 0, 0);
    chk("ld.keep_ovf", 64'(bus1.ovf), 64'h8);
    step(1, 3, 1, 0, 0, 0, 0);
    chk("clr.w10.ovf", 64'(bus1.ovf), 64'h0);
    chk("clr.s10.ovf", 64'(bus2.ovf), 64'h0);

    step(1, 0, 0, 1, 8'd7, 0, 0);
    step(1, 0, 0, 0, 8'd3, 1, 0);
    chk("same.pre", 64'(bus0.sum), 64'h7);
    show(0);
    chk("same.post", 64'(bus0.sum), 64'hA);
    step(1, 0, 1, 1, 8'd9, 0, 0);
    show(0);
    chk("clr_prio", 64'(bus0.sum), 64'h0);

    for (int i = 0; i < 3; i++) begin
      show(1);
      chk("held.sv", 64'(bus0.sum_valid), 64'h1);
      chk("held.sum", 64'(bus0.sum), 64'h5);
    end

    add(2, 8'h10);
    reset = 1'b0;
    step(1, 2, 0, 0, 8'h20, 1, 2);
    chk("mid.sum", 64'(bus0.sum), 64'h0);
    chk("mid.sv", 64'(bus0.sum_valid), 64'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      show(2'(i));
      chk("post.sum", 64'(bus0.sum), 64'h0);
    end
    chk("post.ovf", 64'(bus0.ovf), 64'h0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_accumulator.md
MULTI_ACCUMULATOR -- requirements
Module: multi_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the input operand.
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent accumulator channels (>=1).
REQ-003 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH, width of each accumulator (>DATA_WIDTH).
REQ-004 SHALL have parameter SATURATE, default 0; 0 = wrap on overflow, 1 = clamp to all-ones.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port valid  input  1  qualifies the operation on ch this cycle.
REQ-008 SHALL have port ch  input  max(1,$clog2(NUM_CH))  target channel of clear/load/add.
REQ-009 SHALL have port clear  input  1  with valid, zero acc[ch] and ovf[ch].
REQ-010 SHALL have port load  input  1  with valid, acc[ch] = value, zero-extended.
REQ-011 SHALL have port value  input  DATA_WIDTH  operand.
REQ-012 SHALL have port display  input  1  capture acc[disp_ch] into sum.
REQ-013 SHALL have port disp_ch  input  same width as ch  channel to display.
REQ-014 SHALL have port sum  output  ACC_WIDTH  registered displayed value.
REQ-015 SHALL have port sum_valid  output  1  one-cycle pulse after each capture.
REQ-016 SHALL have port ovf  output  NUM_CH  sticky per-channel overflow flags.

Function
REQ-017 With valid=1, operation on acc[ch] SHALL have priority clear > load > add; add is acc[ch] + zero-extended value.
REQ-018 With valid=0, no accumulator or ovf bit SHALL change; load/clear SHALL be ignored.
REQ-019 An add whose carry out of ACC_WIDTH is set SHALL set ovf[ch]; result is the low ACC_WIDTH bits when SATURATE=0, all-ones when SATURATE=1.
REQ-020 A load SHALL not clear ovf[ch]; only clear or reset clears it.
REQ-021 ch or disp_ch >= NUM_CH SHALL be ignored (no update; display leaves sum unchanged, no sum_valid).
REQ-022 display=1 at an edge SHALL load sum with acc[disp_ch] as it was before that edge; latency one cycle; sum_valid=1 for exactly that following cycle.
REQ-023 sum SHALL hold its value between displays regardless of subsequent clear/load/add activity.
REQ-024 display and valid in the same cycle on the same channel SHALL both take effect; sum gets the pre-update value.
REQ-025 display held high for N cycles SHALL capture every cycle and hold sum_valid high for N cycles.
REQ-026 Operations on one channel SHALL never affect another channel's accumulator or ovf bit.

Reset
REQ-027 reset=0 at a rising edge SHALL zero all accumulators, sum, sum_valid and ovf, overriding every other input that cycle.
REQ-028 Reset asserted mid-sequence SHALL discard the in-flight operation; first post-reset operation sees all-zero state.

Structure
REQ-029 A shared package accum_pkg SHALL hold default parameter constants and a function computing the channel-index width.
REQ-030 Per-channel accumulate/overflow/saturate logic SHALL be one sub-module, acc_lane, instantiated NUM_CH times; display mux and sum register live in the top.

Verification (DATA_WIDTH=8, NUM_CH=4 unless stated)
REQ-031 Reset then display ch0..3 -> sum=0x0000 each time, ovf=4'b0000, sum_valid pulses once per display.
REQ-032 ch0 add 1,2,4, display ch0 -> sum=0x0007; add 4 -> sum stays 0x0007; display -> 0x000B.
REQ-033 load ch1=5, add ch2 0xFF x4, display ch1 -> 0x0005, display ch2 -> 0x03FC; ch0/ch3 remain 0.
REQ-034 ACC_WIDTH=10, add 0xFF x5 on ch3: SATURATE=0 -> sum=0x0FB, ovf[3]=1; SATURATE=1 -> sum=0x3FF, ovf[3]=1; clear ch3 -> ovf[3]=0.
REQ-035 acc ch0=7, same cycle add 3 on ch0 and display ch0 -> sum=0x0007; next display -> 0x000A; clear+load+add together -> acc=0.
REQ-036 Reset asserted while adding on ch2 with display high -> sum=0, sum_valid=0, all channels read 0 after release.
